// File: rtl/sa_int_os_if.sv
// Job control, operand-beat and result-row bus of the integer output-stationary array.
// master = job producer / result consumer, slave = the array.
interface sa_int_os_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 16,
   parameter int AW   = 40,
   parameter int KW   = 8
);
   localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                 start;
   logic [KW-1:0]        k_len;
   logic                 busy;
   logic                 in_valid;
   logic                 in_ready;
   logic [ROWS*DW-1:0]   in_a;
   logic [COLS*DW-1:0]   in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [COLS*AW-1:0]   out_row;
   logic [IDXW-1:0]      out_row_idx;
   logic                 done;

   modport master (
      output start, k_len, in_valid, in_a, in_b, out_ready,
      input  busy, in_ready, out_valid, out_row, out_row_idx, done
   );

   modport slave (
      input  start, k_len, in_valid, in_a, in_b, out_ready,
      output busy, in_ready, out_valid, out_row, out_row_idx, done
   );
endinterface

// File: rtl/sa_int_os_array.sv
// Output-stationary integer systolic array: skews unskewed A/B beats internally,
// accumulates C = A*B in place, then drains one C row per valid/ready transfer.
module sa_int_os_array #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 16,
   parameter int AW   = 40,
   parameter int KW   = 8
) (
   input  logic       clk,
   input  logic       reset,
   sa_int_os_if.slave bus
);
   localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW   = $clog2(ROWS + COLS);
   localparam int PW   = 2 * DW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [KW-1:0]      k_len_q, k_len_d;
   logic [KW-1:0]      beat_cnt_q, beat_cnt_d;
   logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic               done_q, done_d;

   // Skew lines hold {valid, data}; lane i of A is read at stage i, lane j of B at stage j.
   logic [DW:0]          sk_a_q [ROWS][ROWS];
   logic [DW:0]          sk_a_d [ROWS][ROWS];
   logic [DW:0]          sk_b_q [COLS][COLS];
   logic [DW:0]          sk_b_d [COLS][COLS];
   logic signed [DW-1:0] pe_a_q [ROWS][COLS];
   logic signed [DW-1:0] pe_a_d [ROWS][COLS];
   logic signed [DW-1:0] pe_b_q [ROWS][COLS];
   logic signed [DW-1:0] pe_b_d [ROWS][COLS];
   logic                 pe_av_q [ROWS][COLS];
   logic                 pe_av_d [ROWS][COLS];
   logic                 pe_bv_q [ROWS][COLS];
   logic                 pe_bv_d [ROWS][COLS];
   logic signed [AW-1:0] acc_q [ROWS][COLS];
   logic signed [AW-1:0] acc_d [ROWS][COLS];

   logic signed [DW-1:0] a_in_s [ROWS][COLS];
   logic signed [DW-1:0] b_in_s [ROWS][COLS];
   logic                 av_in_s [ROWS][COLS];
   logic                 bv_in_s [ROWS][COLS];
   logic signed [PW-1:0] prod_s [ROWS][COLS];

   logic               busy_s, in_ready_s, out_valid_s, accept_s, fire_s, clear_s;
   logic [COLS*AW-1:0] out_row_s;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and job counters.
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      beat_cnt_d  = beat_cnt_q;
      flush_cnt_d = flush_cnt_q;
      idx_d       = idx_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               k_len_d    = bus.k_len;
               beat_cnt_d = '0;
               idx_d      = '0;
               state_d    = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (accept_s && (beat_cnt_q == k_len_q - KW'(1))) begin
               state_d     = S_FLUSH;
               flush_cnt_d = '0;
            end else if (accept_s) begin
               beat_cnt_d = beat_cnt_q + KW'(1);
            end else begin
               state_d = S_LOAD;
            end
         end
         S_FLUSH: begin
            // The last beat reaches the far corner PE ROWS+COLS-1 edges after acceptance.
            if (flush_cnt_q == FW'(ROWS + COLS - 2)) begin
               state_d = S_DRAIN;
            end else begin
               flush_cnt_d = flush_cnt_q + FW'(1);
            end
         end
         S_DRAIN: begin
            if (fire_s && (idx_q == IDXW'(ROWS - 1))) begin
               state_d = S_IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else if (fire_s) begin
               idx_d = idx_q + IDXW'(1);
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the state register and the row mux.
   always_comb begin
      busy_s      = (state_q != S_IDLE);
      in_ready_s  = (state_q == S_LOAD);
      out_valid_s = (state_q == S_DRAIN);
      accept_s    = in_ready_s & bus.in_valid;
      fire_s      = out_valid_s & bus.out_ready;
      clear_s     = (state_q == S_IDLE) & bus.start;
      out_row_s   = '0;
      for (int j = 0; j < COLS; j++) begin
         out_row_s[j*AW +: AW] = acc_q[idx_q][j];
      end
   end

   // PE operand sources: skew line outputs on the edges, neighbour registers inside.
   always_comb begin
      a_in_s  = '{default: '0};
      b_in_s  = '{default: '0};
      av_in_s = '{default: 1'b0};
      bv_in_s = '{default: 1'b0};
      for (int i = 0; i < ROWS; i++) begin
         a_in_s[i][0]  = sk_a_q[i][i][DW-1:0];
         av_in_s[i][0] = sk_a_q[i][i][DW];
         for (int j = 1; j < COLS; j++) begin
            a_in_s[i][j]  = pe_a_q[i][j-1];
            av_in_s[i][j] = pe_av_q[i][j-1];
         end
      end
      for (int j = 0; j < COLS; j++) begin
         b_in_s[0][j]  = sk_b_q[j][j][DW-1:0];
         bv_in_s[0][j] = sk_b_q[j][j][DW];
         for (int i = 1; i < ROWS; i++) begin
            b_in_s[i][j]  = pe_b_q[i-1][j];
            bv_in_s[i][j] = pe_bv_q[i-1][j];
         end
      end
   end

   // Skew shift, PE forwarding and multiply-accumulate.
   always_comb begin
      sk_a_d  = sk_a_q;
      sk_b_d  = sk_b_q;
      prod_s  = '{default: '0};
      pe_a_d  = '{default: '0};
      pe_b_d  = '{default: '0};
      pe_av_d = '{default: 1'b0};
      pe_bv_d = '{default: 1'b0};
      acc_d   = acc_q;
      for (int i = 0; i < ROWS; i++) begin
         sk_a_d[i][0] = {accept_s, bus.in_a[i*DW +: DW]};
         for (int s = 1; s < ROWS; s++) begin
            sk_a_d[i][s] = sk_a_q[i][s-1];
         end
      end
      for (int j = 0; j < COLS; j++) begin
         sk_b_d[j][0] = {accept_s, bus.in_b[j*DW +: DW]};
         for (int s = 1; s < COLS; s++) begin
            sk_b_d[j][s] = sk_b_q[j][s-1];
         end
      end
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            pe_a_d[i][j]  = a_in_s[i][j];
            pe_b_d[i][j]  = b_in_s[i][j];
            pe_av_d[i][j] = av_in_s[i][j];
            pe_bv_d[i][j] = bv_in_s[i][j];
            prod_s[i][j]  = PW'(a_in_s[i][j]) * PW'(b_in_s[i][j]);
            if (clear_s) begin
               acc_d[i][j] = '0;
            end else if (av_in_s[i][j] && bv_in_s[i][j]) begin
               acc_d[i][j] = acc_q[i][j] + AW'(prod_s[i][j]);
            end else begin
               acc_d[i][j] = acc_q[i][j];
            end
         end
      end
   end

   // Counters, skew lines, PE pipeline and accumulators.
   always_ff @(posedge clk) begin
      if (!reset) begin
         k_len_q     <= '0;
         beat_cnt_q  <= '0;
         flush_cnt_q <= '0;
         idx_q       <= '0;
         done_q      <= 1'b0;
         sk_a_q      <= '{default: '0};
         sk_b_q      <= '{default: '0};
         pe_a_q      <= '{default: '0};
         pe_b_q      <= '{default: '0};
         pe_av_q     <= '{default: 1'b0};
         pe_bv_q     <= '{default: 1'b0};
         acc_q       <= '{default: '0};
      end else begin
         k_len_q     <= k_len_d;
         beat_cnt_q  <= beat_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
         sk_a_q      <= sk_a_d;
         sk_b_q      <= sk_b_d;
         pe_a_q      <= pe_a_d;
         pe_b_q      <= pe_b_d;
         pe_av_q     <= pe_av_d;
         pe_bv_q     <= pe_bv_d;
         acc_q       <= acc_d;
      end
   end

   assign bus.busy        = busy_s;
   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_s;
   assign bus.out_row     = out_row_s;
   assign bus.out_row_idx = idx_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_sa_int_os_array.sv
// Bench for sa_int_os_array: a table of directed and random jobs, expected C from
// constants or a plain matrix-multiply model, plus mid-job reset and re-run.
module tb_sa_int_os_array;
   localparam int R    = 4;
   localparam int C    = 4;
   localparam int KMAX = 16;
   localparam int NT   = 11;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sa_int_os_if              bus   ();
   sa_int_os_if #(.AW(32))   bus32 ();

   sa_int_os_array dut (.clk(clk), .reset(reset), .bus(bus));
   sa_int_os_array #(.AW(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

   assign bus32.start     = bus.start;
   assign bus32.k_len     = bus.k_len;
   assign bus32.in_valid  = bus.in_valid;
   assign bus32.in_a      = bus.in_a;
   assign bus32.in_b      = bus.in_b;
   assign bus32.out_ready = bus.out_ready;

   typedef struct {
      int                                k;
      int                                gap;
      int                                gap_at;
      int                                rdy_mode;
      bit                                busy_start;
      logic [R-1:0][KMAX-1:0][15:0]      a;
      logic [KMAX-1:0][C-1:0][15:0]      b;
      logic [R-1:0][C-1:0][39:0]         c;
      logic [R-1:0][C-1:0][31:0]         c32;
   } vec_t;

   vec_t vecs [NT];
   int   n_err = 0;
   int   n_chk = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^40 and 2^32.
   task automatic ref_mm(input vec_t v, output logic [R-1:0][C-1:0][39:0] c40,
                         output logic [R-1:0][C-1:0][31:0] c32);
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            longint s;
            s = 0;
            for (int kk = 0; kk < v.k; kk++) begin
               s += longint'($signed(v.a[i][kk])) * longint'($signed(v.b[kk][j]));
            end
            c40[i][j] = s[39:0];
            c32[i][j] = s[31:0];
         end
      end
   endtask

   task automatic run_job(input vec_t v, input string tag);
      int             beat, gap_left, guard, n, row, cyc;
      logic           rdy;
      logic [R*16-1:0] av;
      bus.start = 1'b1;
      bus.k_len = 8'(v.k);
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "/busy_rise"}, bus.busy, 1'b1);
      if (v.k == 0) check({tag, "/no_load"}, bus.in_ready, 1'b0);
      beat = 0;
      gap_left = v.gap;
      guard = 0;
      while (beat < v.k && guard < 200) begin
         check({tag, "/in_ready_load"}, bus.in_ready, 1'b1);
         if (v.busy_start) begin
            bus.start = 1'b1;
            bus.k_len = 8'd7;
         end
         if (beat == v.gap_at && gap_left > 0) begin
            bus.in_valid = 1'b0;
            gap_left--;
         end else begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < R; i++) av[i*16 +: 16] = v.a[i][beat];
            bus.in_a = av;
            bus.in_b = v.b[beat];
         end
         @(negedge clk);
         if (bus.in_valid) beat++;
         guard++;
      end
      check({tag, "/beats_taken"}, beat, v.k);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         check({tag, "/in_ready_flush"}, bus.in_ready, 1'b0);
         @(negedge clk);
         n++;
      end
      check({tag, "/flush_len"}, n, (v.k == 0) ? 0 : R + C - 1);
      row = 0;
      cyc = 0;
      while (row < R && cyc < 100) begin
         case (v.rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         check({tag, "/out_valid"}, bus.out_valid, 1'b1);
         check({tag, "/row_idx"}, bus.out_row_idx, row);
         check({tag, "/row"}, bus.out_row, v.c[row]);
         check({tag, "/row_aw32"}, bus32.out_row, v.c32[row]);
         check({tag, "/busy_drain"}, bus.busy, 1'b1);
         check({tag, "/done_early"}, bus.done, 1'b0);
         bus.out_ready = rdy;
         @(negedge clk);
         if (rdy) row++;
         cyc++;
      end
      bus.out_ready = 1'b0;
      check({tag, "/rows_drained"}, row, R);
      check({tag, "/done_pulse"}, bus.done, 1'b1);
      check({tag, "/busy_fall"}, bus.busy, 1'b0);
      check({tag, "/out_valid_fall"}, bus.out_valid, 1'b0);
      @(negedge clk);
      check({tag, "/done_single"}, bus.done, 1'b0);
   endtask

   initial begin
      logic [R-1:0][C-1:0][39:0] t40;
      logic [R-1:0][C-1:0][31:0] t32;
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      for (int t = 0; t < NT; t++) begin
         vecs[t].k = 0; vecs[t].gap = 0; vecs[t].gap_at = 0;
         vecs[t].rdy_mode = 0; vecs[t].busy_start = 1'b0;
         vecs[t].a = '0; vecs[t].b = '0; vecs[t].c = '0; vecs[t].c32 = '0;
      end
      // job0: 2x2 corner of a 4x4 job, K=2
      vecs[0].k = 2;
      vecs[0].a[0][0] = 16'd1; vecs[0].a[1][0] = 16'd3;
      vecs[0].a[0][1] = 16'd2; vecs[0].a[1][1] = 16'd4;
      vecs[0].b[0][0] = 16'd2; vecs[0].b[0][1] = 16'd3;
      vecs[0].b[1][0] = 16'd4; vecs[0].b[1][1] = 16'd5;
      vecs[0].c[0][0] = 40'd10; vecs[0].c[0][1] = 40'd13;
      vecs[0].c[1][0] = 40'd22; vecs[0].c[1][1] = 40'd29;
      // job1: same job with a 3-cycle bubble and start held during LOAD
      vecs[1] = vecs[0];
      vecs[1].gap = 3; vecs[1].gap_at = 1; vecs[1].busy_start = 1'b1;
      // job2: identity times B, stalling consumer
      vecs[2].k = 4; vecs[2].rdy_mode = 1;
      for (int i = 0; i < 4; i++) begin
         vecs[2].a[i][i] = 16'd1;
         for (int j = 0; j < 4; j++) begin
            vecs[2].b[i][j] = 16'(i * 4 + j + 1);
            vecs[2].c[i][j] = 40'(i * 4 + j + 1);
         end
      end
      // job3: most negative operands, sum exceeds 32 bits
      vecs[3].k = 3;
      for (int i = 0; i < 4; i++) begin
         for (int kk = 0; kk < 3; kk++) begin
            vecs[3].a[i][kk] = 16'h8000;
            vecs[3].b[kk][i] = 16'h8000;
         end
         for (int j = 0; j < 4; j++) vecs[3].c[i][j] = 40'd3221225472;
      end
      // job4: K=0 stays all-zero
      vecs[4].k = 0;
      for (int t = 5; t < NT; t++) begin
         vecs[t].k          = $urandom_range(1, 12);
         vecs[t].gap        = $urandom_range(0, 3);
         vecs[t].gap_at     = $urandom_range(0, vecs[t].k - 1);
         vecs[t].rdy_mode   = 2;
         vecs[t].busy_start = 1'($urandom_range(0, 1));
         for (int kk = 0; kk < vecs[t].k; kk++) begin
            for (int i = 0; i < 4; i++) vecs[t].a[i][kk] = 16'($urandom);
            for (int j = 0; j < 4; j++) vecs[t].b[kk][j] = 16'($urandom);
         end
      end
      for (int t = 0; t < NT; t++) begin
         ref_mm(vecs[t], t40, t32);
         vecs[t].c32 = t32;
         if (t >= 5) vecs[t].c = t40;
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) vecs[3].c32[i][j] = 32'hC000_0000;
      end

      repeat (2) @(negedge clk);
      check("reset/busy", bus.busy, 1'b0);
      check("reset/in_ready", bus.in_ready, 1'b0);
      check("reset/out_valid", bus.out_valid, 1'b0);
      check("reset/done", bus.done, 1'b0);
      check("reset/row_idx", bus.out_row_idx, 0);
      check("reset/out_row", bus.out_row, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int t = 0; t < NT; t++) run_job(vecs[t], $sformatf("job%0d", t));

      // Abandon a job after its first beat.
      bus.start = 1'b1;
      bus.k_len = 8'd2;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = {16'd0, 16'd0, 16'd3, 16'd1};
      bus.in_b     = vecs[0].b[0];
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset        = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midreset/busy", bus.busy, 1'b0);
      check("midreset/in_ready", bus.in_ready, 1'b0);
      check("midreset/out_valid", bus.out_valid, 1'b0);
      check("midreset/done", bus.done, 1'b0);
      check("midreset/row_idx", bus.out_row_idx, 0);
      check("midreset/out_row", bus.out_row, 0);
      @(negedge clk);
      check("midreset/no_done", bus.done, 1'b0);
      check("midreset/idle", bus.busy, 1'b0);

      run_job(vecs[0], "rerun");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end
endmodule

// File: doc/sa_int_os_array.md
Name: sa_int_os_array

Overview:
- Parametrised output-stationary integer systolic array (ROWS x COLS) for the matrix-multiply datapath. Successor to the double-precision MxN array.
- Computes C = A * B over a programmable inner dimension K.
  - Accepts one unskewed beat per cycle: column k of A and row k of B.
  - Skews the beats internally.
- Accumulates in place, then drains C one row per beat over a valid/ready handshake.

Parameters:
- ROWS, 4, PE rows; also the number of A lanes and C rows.
- COLS, 4, PE columns; also the number of B lanes and C columns.
- DW, 16, signed operand width.
- AW, 40, signed accumulator width; must be at least 2*DW.
- KW, 8, width of k_len.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension K; sampled with start.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  an operand beat is present.
- in_ready  out  1  high only in LOAD.
- in_a  in  ROWS*DW  lane i = A[i][k], little-endian lane packing.
- in_b  in  COLS*DW  lane j = B[k][j].
- out_valid  out  1  a C row is presented.
- out_ready  in  1  the consumer accepts the row.
- out_row  out  COLS*AW  lane j = C[out_row_idx][j].
- out_row_idx  out  clog2(ROWS) (min 1)  index of the presented row.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE; all accumulators, skew registers and PE pipeline registers are cleared.
  - busy, in_ready, out_valid, done and out_row_idx are 0; out_row is 0.
  - Reset mid-job abandons the job with no done pulse.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start=1 clears all accumulators and latches k_len.
  - Next state is LOAD if k_len != 0, otherwise DRAIN.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - A beat counter counts accepted beats; after beat K is accepted, next state is FLUSH.
  - Cycles with in_valid=0 inject a bubble. The pipeline never stalls.
- Skew and dataflow:
  - A lane i is delayed i cycles and B lane j is delayed j cycles. Each carries a valid bit.
  - Each PE registers a one step right and b one step down, passing the valid bit with them.
  - For a beat accepted at cycle t, PE(i,j) adds the product at posedge t+i+j+1.
  - A PE accumulates only when both incoming valid bits are 1, so bubbles and zero-padding never corrupt results.
- Arithmetic:
  - acc += sext(a)*sext(b), a full 2*DW signed product sign-extended to AW.
  - Accumulation wraps modulo 2^AW. There is no saturation.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles after the last accepted beat, then state goes to DRAIN.
  - in_ready=0 during FLUSH.
- DRAIN:
  - out_valid=1; out_row_idx starts at 0; out_row shows the accumulators of that row.
  - On out_valid & out_ready, out_row_idx increments.
  - When row ROWS-1 is accepted, state goes to IDLE and done=1 for the next cycle.
  - Outputs hold stable while out_ready=0.
- busy:
  - Rises the cycle after start is accepted.
  - Falls together with the done pulse, so busy=0 when done=1.

Test Plan:
- Defaults (4x4), K=2.
  - Stimulus: A cols {1,3,0,0},{2,4,0,0}; B rows {2,3,0,0},{4,5,0,0}; out_ready=1.
  - Required: rows [10,13,0,0], [22,29,0,0], [0..], [0..]; done one cycle after row 3.
- Same job with in_valid low for 3 cycles between the two beats.
  - Required: identical C.
  - in_ready stays 1 during the gap; FLUSH still lasts 7 cycles after the last beat.
- K=4, A=I4, B rows {1,2,3,4}..{13,14,15,16}; out_ready toggled 1,0,0,1,...
  - Required: C=B.
  - out_row and out_row_idx hold during out_ready=0; exactly 4 transfers, no skipped or repeated row.
- Signed and wrap case, K=3, all A lanes = -32768, all B lanes = -32768.
  - Required: every C = 3*2^30 = 3221225472.
  - Repeating with AW=32 gives 3221225472 mod 2^32 as signed, which is -1073741824.
- Edge cases:
  - k_len=0: expect 4 zero rows, done pulse, no LOAD cycles.
  - start while busy: must be ignored.
- Reset and re-run:
  - Drive reset=0 for 1 cycle after 1 of 2 beats; expect busy=0 and outputs 0 next cycle.
  - Run the first scenario again; expect the exact first-scenario results with no residue.
